// File: rtl/riscv_isa_pkg.sv
// rtl/riscv_isa_pkg.sv - shared RISC-V ISA constants: CSR addresses, cause codes, trap FSM states
package riscv_isa_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [3:0] {
        CAUSE_MSI = 4'd3,
        CAUSE_MTI = 4'd7,
        CAUSE_MEI = 4'd11
    } irq_cause_t;

    typedef enum logic {
        TRAP_RUN   = 1'b0,
        TRAP_FLUSH = 1'b1
    } trap_fsm_t;

endpackage

// File: rtl/r5p_trap_irq_pri.sv
// rtl/r5p_trap_irq_pri.sv - machine interrupt priority encoder (MEI > MSI > MTI)
module r5p_trap_irq_pri
    import riscv_isa_pkg::*;
(
    input  logic [2:0] pend,
    output logic       vld,
    output logic [3:0] code
);

    // pend is ordered {mei, mti, msi}
    always_comb begin
        vld  = |pend;
        code = 4'd0;
        if (pend[2]) begin
            code = CAUSE_MEI;
        end else if (pend[0]) begin
            code = CAUSE_MSI;
        end else if (pend[1]) begin
            code = CAUSE_MTI;
        end
    end

endmodule

// File: rtl/r5p_trap.sv
// rtl/r5p_trap.sv - machine-mode trap CSRs and PC redirect; R5P_TRAP_VECTORED_EN enables vectored mtvec
module r5p_trap
    import riscv_isa_pkg::*;
#(
    parameter int            XW        = 32,
    parameter logic [XW-1:0] MTVEC_RST = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          csr_wen,
    input  logic [11:0]   csr_adr,
    input  logic [XW-1:0] csr_wdt,
    output logic [XW-1:0] csr_rdt,
    output logic          csr_hit,
    input  logic          exc_vld,
    input  logic [3:0]    exc_cause,
    input  logic [XW-1:0] exc_tval,
    input  logic          ret_vld,
    input  logic          ins_vld,
    input  logic [XW-1:0] ins_pc,
    input  logic          irq_msi,
    input  logic          irq_mti,
    input  logic          irq_mei,
    output logic          trp_vld,
    output logic [XW-1:0] trp_pc
);

    localparam logic [XW-1:0] ALIGN = {{(XW-2){1'b1}}, 2'b00};
`ifdef R5P_TRAP_VECTORED_EN
    localparam logic [XW-1:0] MTVEC_WMASK = {{(XW-2){1'b1}}, 2'b01};
`else
    localparam logic [XW-1:0] MTVEC_WMASK = ALIGN;
`endif

    trap_fsm_t     state;
    logic          st_mie;
    logic          st_mpie;
    logic [2:0]    ie;
    logic [XW-1:0] mtvec;
    logic [XW-1:0] mepc;
    logic [XW-1:0] mcause;
    logic [XW-1:0] mtval;

    logic [2:0]    ip;
    logic          irq_vld;
    logic [3:0]    irq_code;
    logic          take_exc;
    logic          take_irq;
    logic          take_ret;
    logic          take_trap;
    logic [XW-1:0] base;
    logic [XW-1:0] irq_tgt;
    logic [XW-1:0] target;

    assign ip = {irq_mei, irq_mti, irq_msi};

    r5p_trap_irq_pri u_irq_pri (
        .pend (ip & ie & {3{st_mie}}),
        .vld  (irq_vld),
        .code (irq_code)
    );

    // While flushing, the pipeline's trap/ret signals belong to squashed instructions.
    assign take_exc  = (state == TRAP_RUN) && exc_vld;
    assign take_irq  = (state == TRAP_RUN) && !exc_vld && ins_vld && irq_vld && !ret_vld;
    assign take_ret  = (state == TRAP_RUN) && !exc_vld && ret_vld;
    assign take_trap = take_exc || take_irq;

    assign base = mtvec & ALIGN;

`ifdef R5P_TRAP_VECTORED_EN
    assign irq_tgt = mtvec[0] ? base + {{(XW-6){1'b0}}, irq_code, 2'b00} : base;
`else
    assign irq_tgt = base;
`endif

    assign target = take_ret ? mepc : (take_irq ? irq_tgt : base);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TRAP_RUN;
            trp_vld <= 1'b0;
            trp_pc  <= '0;
        end else begin
            case (state)
                TRAP_RUN: begin
                    if (take_trap || take_ret) begin
                        state   <= TRAP_FLUSH;
                        trp_vld <= 1'b1;
                        trp_pc  <= target;
                    end else begin
                        trp_vld <= 1'b0;
                    end
                end
                default: begin
                    state   <= TRAP_RUN;
                    trp_vld <= 1'b0;
                end
            endcase
        end
    end

    // Trap entry overrides any same-cycle software write to the trap state CSRs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            ie      <= '0;
            mtvec   <= MTVEC_RST & ALIGN;
            mepc    <= '0;
            mcause  <= '0;
            mtval   <= '0;
        end else begin
            if (csr_wen && csr_adr == CSR_MIE) begin
                ie <= {csr_wdt[11], csr_wdt[7], csr_wdt[3]};
            end
            if (csr_wen && csr_adr == CSR_MTVEC) begin
                mtvec <= csr_wdt & MTVEC_WMASK;
            end
            if (take_trap) begin
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
                if (take_exc) begin
                    mepc   <= ins_pc & ALIGN;
                    mcause <= {{(XW-4){1'b0}}, exc_cause};
                    mtval  <= exc_tval;
                end else begin
                    mepc   <= (ins_pc + XW'(4)) & ALIGN;
                    mcause <= {1'b1, {(XW-5){1'b0}}, irq_code};
                    mtval  <= '0;
                end
            end else begin
                if (take_ret) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end else if (csr_wen && csr_adr == CSR_MSTATUS) begin
                    st_mie  <= csr_wdt[MSTATUS_MIE];
                    st_mpie <= csr_wdt[MSTATUS_MPIE];
                end
                if (csr_wen && csr_adr == CSR_MEPC) begin
                    mepc <= csr_wdt & ALIGN;
                end
                if (csr_wen && csr_adr == CSR_MCAUSE) begin
                    mcause <= csr_wdt;
                end
                if (csr_wen && csr_adr == CSR_MTVAL) begin
                    mtval <= csr_wdt;
                end
            end
        end
    end

    always_comb begin
        csr_hit = 1'b1;
        csr_rdt = '0;
        case (csr_adr)
            CSR_MSTATUS: begin
                csr_rdt[MSTATUS_MIE]  = st_mie;
                csr_rdt[MSTATUS_MPIE] = st_mpie;
            end
            CSR_MIE: begin
                csr_rdt[11] = ie[2];
                csr_rdt[7]  = ie[1];
                csr_rdt[3]  = ie[0];
            end
            CSR_MTVEC:  csr_rdt = mtvec;
            CSR_MEPC:   csr_rdt = mepc;
            CSR_MCAUSE: csr_rdt = mcause;
            CSR_MTVAL:  csr_rdt = mtval;
            CSR_MIP: begin
                csr_rdt[11] = ip[2];
                csr_rdt[7]  = ip[1];
                csr_rdt[3]  = ip[0];
            end
            default: csr_hit = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_r5p_trap.sv
// tb/tb_r5p_trap.sv - self-checking bench for r5p_trap against a behavioural CSR/trap model
module tb_r5p_trap;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0203;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_wen = 1'b0;
    logic [11:0] csr_adr = '0;
    logic [31:0] csr_wdt = '0;
    logic [31:0] csr_rdt;
    logic        csr_hit;
    logic        exc_vld = 1'b0;
    logic [3:0]  exc_cause = '0;
    logic [31:0] exc_tval = '0;
    logic        ret_vld = 1'b0;
    logic        ins_vld = 1'b0;
    logic [31:0] ins_pc = '0;
    logic        irq_msi = 1'b0;
    logic        irq_mti = 1'b0;
    logic        irq_mei = 1'b0;
    logic        trp_vld;
    logic [31:0] trp_pc;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    r5p_trap #(.XW(32), .MTVEC_RST(MTVEC_RST)) dut (
        .clk(clk), .rst(rst),
        .csr_wen(csr_wen), .csr_adr(csr_adr), .csr_wdt(csr_wdt),
        .csr_rdt(csr_rdt), .csr_hit(csr_hit),
        .exc_vld(exc_vld), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .ret_vld(ret_vld), .ins_vld(ins_vld), .ins_pc(ins_pc),
        .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei),
        .trp_vld(trp_vld), .trp_pc(trp_pc)
    );

    always #5 clk = ~clk;

    // Architectural state of the model, kept as plain 32-bit CSR images.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        m_trp_vld;
    logic [31:0] m_trp_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = MTVEC_RST & ~32'h3;
        m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_trp_vld = 0; m_trp_pc = 0;
    endtask

    function automatic logic [31:0] mip_now();
        return ({31'd0, irq_mei} << 11) | ({31'd0, irq_mti} << 7) | ({31'd0, irq_msi} << 3);
    endfunction

    function automatic logic [32:0] m_read(input logic [11:0] adr);
        case (adr)
            12'h300: return {1'b1, m_mstatus};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, mip_now()};
            default: return 33'd0;
        endcase
    endfunction

    // One clock of architectural behaviour, evaluated from the inputs present at the edge.
    task automatic model_step();
        logic [31:0] pend, base, tgt, wmask;
        int code, kind;
        bit mie_b, mpie_b;
        if (rst) begin
            model_reset();
            return;
        end
        pend = m_mstatus[3] ? (mip_now() & m_mie) : 0;
        code = pend[11] ? 11 : pend[3] ? 3 : pend[7] ? 7 : 0;
        base = m_mtvec & ~32'h3;
        mie_b = m_mstatus[3];
        mpie_b = m_mstatus[7];
        kind = 0;
        tgt = 0;
        if (!m_trp_vld) begin
            if (exc_vld) begin
                kind = 1; tgt = base;
            end else if (ins_vld && pend != 0 && !ret_vld) begin
                kind = 2; tgt = base;
`ifdef R5P_TRAP_VECTORED_EN
                if (m_mtvec[0]) tgt = base + 32'(4 * code);
`endif
            end else if (ret_vld) begin
                kind = 3; tgt = m_mepc;
            end
        end
`ifdef R5P_TRAP_VECTORED_EN
        wmask = 32'hFFFF_FFFD;
`else
        wmask = 32'hFFFF_FFFC;
`endif
        if (csr_wen) begin
            case (csr_adr)
                12'h300: m_mstatus = csr_wdt & 32'h88;
                12'h304: m_mie = csr_wdt & 32'h888;
                12'h305: m_mtvec = csr_wdt & wmask;
                12'h341: m_mepc = csr_wdt & ~32'h3;
                12'h342: m_mcause = csr_wdt;
                12'h343: m_mtval = csr_wdt;
                default: ;
            endcase
        end
        if (kind == 1 || kind == 2) begin
            m_mstatus = mie_b ? 32'h80 : 32'h0;
            m_mepc = (kind == 1) ? (ins_pc & ~32'h3) : ((ins_pc + 4) & ~32'h3);
            m_mcause = (kind == 1) ? {28'd0, exc_cause} : (32'h8000_0000 | 32'(code));
            m_mtval = (kind == 1) ? exc_tval : 32'h0;
        end else if (kind == 3) begin
            m_mstatus = 32'h80 | (mpie_b ? 32'h8 : 32'h0);
        end
        m_trp_vld = (kind != 0);
        if (kind != 0) m_trp_pc = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        csr_wen = 0; exc_vld = 0; ret_vld = 0; ins_vld = 0;
        irq_msi = 0; irq_mti = 0; irq_mei = 0;
    endtask

    task automatic wr(input logic [11:0] adr, input logic [31:0] d);
        csr_wen = 1; csr_adr = adr; csr_wdt = d;
        step();
        csr_wen = 0;
    endtask

    task automatic rd(input string nm, input logic [11:0] adr, input logic [31:0] exp);
        csr_adr = adr;
        #1;
        chk(nm, csr_rdt, exp);
    endtask

    always @(negedge clk) begin
        logic [32:0] r;
        if (!rst && chk_en) begin
            r = m_read(csr_adr);
            chk("cmp_trp_vld", {31'd0, trp_vld}, {31'd0, m_trp_vld});
            if (m_trp_vld) chk("cmp_trp_pc", trp_pc, m_trp_pc);
            chk("cmp_csr_hit", {31'd0, csr_hit}, {31'd0, r[32]});
            chk("cmp_csr_rdt", csr_rdt, r[31:0]);
        end
    end

    initial begin
        logic [11:0] adrs [9];
        adrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h301, 12'h7C0};
        model_reset();
        idle();
        repeat (3) step();
        rd("rst_mtvec", 12'h305, 32'h0000_0200);
        rd("rst_mstatus", 12'h300, 32'h0);
        chk("rst_trp_vld", {31'd0, trp_vld}, 32'h0);
        rst = 0;
        chk_en = 1;
        step();
        rd("unowned_rdt", 12'h7C0, 32'h0);
        chk("unowned_hit", {31'd0, csr_hit}, 32'h0);

        wr(12'h305, 32'h100);
        wr(12'h304, 32'h800);
        wr(12'h300, 32'h8);
        irq_mei = 1; ins_vld = 1; ins_pc = 32'h40;
        step();
        idle();
        chk("irq_trp_vld", {31'd0, trp_vld}, 32'h1);
        chk("irq_trp_pc", trp_pc, 32'h100);
        rd("irq_mepc", 12'h341, 32'h44);
        rd("irq_mcause", 12'h342, 32'h8000_000B);
        rd("irq_mstatus", 12'h300, 32'h80);
        step();

        exc_vld = 1; exc_cause = 4'd2; ins_pc = 32'h80; exc_tval = 32'hDEAD_BEEF;
        step();
        idle();
        chk("exc_trp_pc", trp_pc, 32'h100);
        rd("exc_mepc", 12'h341, 32'h80);
        rd("exc_mcause", 12'h342, 32'h2);
        rd("exc_mtval", 12'h343, 32'hDEAD_BEEF);
        step();

        wr(12'h341, 32'h84);
        wr(12'h300, 32'h80);
        ret_vld = 1;
        step();
        idle();
        chk("ret_trp_vld", {31'd0, trp_vld}, 32'h1);
        chk("ret_trp_pc", trp_pc, 32'h84);
        rd("ret_mstatus", 12'h300, 32'h88);
        step();

        exc_vld = 1; exc_cause = 4'd5; ins_pc = 32'h90; ret_vld = 1;
        csr_wen = 1; csr_adr = 12'h342; csr_wdt = 32'h55;
        step();
        idle();
        chk("both_trp_pc", trp_pc, 32'h100);
        rd("both_mcause", 12'h342, 32'h5);
        rd("both_mstatus", 12'h300, 32'h80);
        step();

        wr(12'h305, 32'h101);
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        irq_mti = 1; ins_vld = 1; ins_pc = 32'h200;
        step();
        idle();
`ifdef R5P_TRAP_VECTORED_EN
        chk("vec_trp_pc", trp_pc, 32'h11C);
        rd("vec_mtvec", 12'h305, 32'h101);
`else
        chk("vec_trp_pc", trp_pc, 32'h100);
        rd("vec_mtvec", 12'h305, 32'h100);
`endif
        rd("vec_mcause", 12'h342, 32'h8000_0007);
        step();

        exc_vld = 1; exc_cause = 4'd1; ins_pc = 32'h300;
        step();
        idle();
        rst = 1;
        #1;
        chk("rst_flush_trp_vld", {31'd0, trp_vld}, 32'h0);
        model_reset();
        step();
        rst = 0;
        step();

        for (int i = 0; i < 3000; i++) begin
            csr_wen = ($urandom % 4) == 0;
            csr_adr = adrs[$urandom % 9];
            csr_wdt = $urandom;
            exc_vld = ($urandom % 10) == 0;
            exc_cause = 4'($urandom % 12);
            exc_tval = $urandom;
            ret_vld = ($urandom % 10) == 0;
            ins_vld = $urandom % 2;
            ins_pc = $urandom;
            irq_msi = ($urandom % 3) == 0;
            irq_mti = ($urandom % 3) == 0;
            irq_mei = ($urandom % 4) == 0;
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
